parity_frame_tx_ctrl: RTL and testbench
=======================================

// Module: parity_frame_tx_ctrl
// PURPOSE
//  Frames parallel words into a serial bitstream: accepts a DATA_W word over valid/ready, shifts it
//  out LSB-first one bit per bit_tick, then appends a parity bit. It tracks running parity (1 = odd
//  number of 1s so far) and counts completed frames. Sits between a word producer and a serial line.
// PARAMETERS
//  DATA_W      8   data bits per frame (>=2)
//  ODD_PARITY  0   0: even parity (bit = XOR of data); 1: odd parity (bit = ~XOR of data)
//  CNT_W       16  width of frame_cnt
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  bit_tick   in   1       bit-period strobe; the current serial bit ends on a cycle with bit_tick=1
//  in_data    in   DATA_W  word to transmit
//  in_valid   in   1       in_data valid
//  in_ready   out  1       word accepted on a cycle with in_valid & in_ready
//  ser_out    out  1       serial line; idle level 1
//  ser_valid  out  1       high while a data or parity bit (or start bit) is on ser_out
//  ser_last   out  1       high during the parity-bit period
//  run_par    out  1       running parity of data bits already completed in this frame
//  busy       out  1       state != IDLE
//  frame_cnt  out  CNT_W   number of frames whose parity bit has completed; wraps to 0
// BEHAVIOUR
//  - Reset values: in_ready=1, ser_out=1, ser_valid=0, ser_last=0, run_par=0, busy=0, frame_cnt=0.
//  - States: IDLE -> [START] -> DATA -> PARITY -> IDLE, or PARITY -> [START]/DATA (back-to-back).
//  - IDLE: in_ready=1. On accept at cycle t: shift reg <= in_data, bit_idx <= 0, run_par <= 0.
//    At t+1 the block enters DATA (or START) and ser_out drives the first bit. bit_tick is ignored in IDLE.
//  - DATA: ser_out = shreg[0], ser_valid=1. On bit_tick: run_par ^= shreg[0], shift right, bit_idx++.
//    On the tick that ends bit DATA_W-1, the block moves to PARITY.
//  - PARITY: ser_out = run_par ^ ODD_PARITY, ser_valid=1, ser_last=1.
//    in_ready = bit_tick, so a word can be accepted only on the tick that ends the parity bit.
//    On that tick, frame_cnt increments (modulo 2^CNT_W). If in_valid is high, the new word loads
//    with zero idle gap; otherwise the block returns to IDLE.
//  - in_ready=0 in DATA and START. in_valid without in_ready has no effect; the producer holds its data.
//  - If bit_tick is never asserted, the state holds indefinitely with outputs stable.
//  - rst at any time aborts the frame: no parity bit is emitted, frame_cnt is not incremented, and all
//    outputs return to their reset values on the next cycle.
//  - Parity bit = XOR(in_data) ^ ODD_PARITY; run_par equals the XOR of all data bits when in PARITY.
// CONFIGURATION
//  - START_BIT_EN defined: START state is inserted after accept. It drives ser_out=0, ser_valid=1 for
//    one bit period, then moves to DATA on bit_tick. ser_last and the parity rules are unchanged.
//  - START_BIT_EN undefined: no START state; accept goes directly to DATA.
// STRUCTURE
//  - Shared package parity_ctrl_pkg holds the state encodings (S_IDLE, S_START, S_DATA, S_PARITY)
//    and the parity-sense constants PAR_EVEN=0 and PAR_ODD=1.
//  - Sub-module parity_acc: 1-bit even/odd accumulator (inputs clr, en, x; output par).
//    The controller instantiates it for run_par.
// TESTING
//  1. DATA_W=8, bit_tick=1 every cycle, send 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 then parity 0;
//     ser_last on the parity cycle only; frame_cnt=1.
//  2. Send 8'h07 with bit_tick every 4th cycle -> each bit held 4 cycles; parity bit 1;
//     9 bit periods total; busy deasserts after the last tick.
//  3. ODD_PARITY=1, send 8'h00 -> parity bit 1; send 8'hFF -> parity bit 1.
//  4. Back-to-back: in_valid held high with 8'h01 then 8'h80 -> second word accepted on the parity-bit
//     tick; its bit 0 follows the first parity bit with no idle cycle; frame_cnt=2.
//  5. Assert rst during DATA bit 3 -> next cycle ser_out=1, ser_valid=0, in_ready=1, frame_cnt=0;
//     next frame transmits correctly.
//  6. Preload frame_cnt to 16'hFFFF (force), complete one frame -> frame_cnt=0.
//     Repeat tests 1 and 4 with START_BIT_EN defined -> a 0 start bit precedes each frame's data.

Source files
------------

// File: rtl/parity_ctrl_pkg.sv
// Shared state encodings and parity-sense constants
// for the parity frame transmitter.
package parity_ctrl_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_PARITY = 2'd3;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic logic par_bit(
    input logic acc,
    input int   sense
  );
    return acc ^ (sense != PAR_EVEN);
  endfunction

endpackage

// File: rtl/parity_acc.sv
// One-bit running parity accumulator:
// clr restarts it, en folds x into the sum.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic par
);

  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (clr) begin
      par <= 1'b0;
    end else if (en) begin
      par <= par ^ x;
    end
  end

endmodule

// File: rtl/parity_frame_tx_ctrl.sv
// Word-to-serial framer with trailing parity bit.
// Define START_BIT_EN to prepend a 0 start bit.
module parity_frame_tx_ctrl
  import parity_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = PAR_EVEN,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              run_par,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(DATA_W - 1);

`ifdef START_BIT_EN
  localparam logic [1:0] S_FIRST = S_START;
`else
  localparam logic [1:0] S_FIRST = S_DATA;
`endif

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  cnt_q;

  logic st_idle;
  logic st_start;
  logic st_data;
  logic st_par;
  logic accept;
  logic data_tick;
  logic par_tick;
  logic last_bit;

  assign st_idle  = (state == S_IDLE);
  assign st_start = (state == S_START);
  assign st_data  = (state == S_DATA);
  assign st_par   = (state == S_PARITY);

  assign data_tick = st_data & bit_tick;
  assign par_tick  = st_par & bit_tick;
  assign last_bit  = (bit_idx == LAST_IDX);

  // A new word may only slip in on the tick
  // that closes the parity bit.
  assign in_ready = st_idle | par_tick;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      st_idle: begin
        if (accept) state_nxt = S_FIRST;
      end
      st_start: begin
        if (bit_tick) state_nxt = S_DATA;
      end
      st_data: begin
        if (bit_tick && last_bit)
          state_nxt = S_PARITY;
      end
      st_par: begin
        if (bit_tick)
          state_nxt = accept ? S_FIRST : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg   <= in_data;
        bit_idx <= '0;
      end else if (data_tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (par_tick) cnt_q <= cnt_q + 1'b1;
    end
  end

  parity_acc u_acc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (data_tick),
    .x   (shreg[0]),
    .par (run_par)
  );

  assign ser_out =
    st_idle  ? 1'b1 :
    st_start ? 1'b0 :
    st_data  ? shreg[0] :
               par_bit(run_par, ODD_PARITY);

  assign ser_valid = ~st_idle;
  assign ser_last  = st_par;
  assign busy      = ~st_idle;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_parity_frame_tx_ctrl.sv
// Directed bench for parity_frame_tx_ctrl:
// even/16-bit instance a, odd/2-bit instance b.
module tb_parity_frame_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       bit_tick;
  logic [7:0] in_data;
  logic       va;
  logic       vb;

  logic        ra, soa, sva, sla, rpa, ba;
  logic [15:0] fca;
  logic        rb, sob, svb, slb, rpb, bb;
  logic [1:0]  fcb;

  parity_frame_tx_ctrl #(
    .DATA_W(8), .ODD_PARITY(0), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .bit_tick(bit_tick),
    .in_data(in_data), .in_valid(va),
    .in_ready(ra), .ser_out(soa),
    .ser_valid(sva), .ser_last(sla),
    .run_par(rpa), .busy(ba), .frame_cnt(fca)
  );

  parity_frame_tx_ctrl #(
    .DATA_W(8), .ODD_PARITY(1), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst(rst), .bit_tick(bit_tick),
    .in_data(in_data), .in_valid(vb),
    .in_ready(rb), .ser_out(sob),
    .ser_valid(svb), .ser_last(slb),
    .run_par(rpb), .busy(bb), .frame_cnt(fcb)
  );

  typedef struct {
    logic       sel;
    logic [7:0] data;
    int         per;
    logic       par;
    int         cnt;
  } vec_t;

  vec_t tbl[8];
  int checks = 0;
  int errors = 0;

`ifdef START_BIT_EN
  localparam int NSTART = 1;
`else
  localparam int NSTART = 0;
`endif

  // {ready, ser_out, ser_valid, ser_last, run_par, busy}
  function automatic logic [5:0] outs(input logic s);
    return s ? {rb, sob, svb, slb, rpb, bb}
             : {ra, soa, sva, sla, rpa, ba};
  endfunction

  function automatic int cnt_of(input logic s);
    return s ? int'(fcb) : int'(fca);
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame_body(
    input logic       s,
    input logic [7:0] d,
    input int         p,
    input logic       par
  );
    logic bits[10];
    logic [5:0] o;
    int n;
    n = 0;
    if (NSTART != 0) begin
      bits[n] = 1'b0;
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i];
      n++;
    end
    bits[n] = par;
    n++;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < p; k++) begin
        bit_tick = (k == p - 1);
        #1;
        o = outs(s);
        chk("ser_out", 32'(o[4]), 32'(bits[b]));
        chk("ser_valid", 32'(o[3]), 32'd1);
        chk("ser_last", 32'(o[2]),
            32'(b == n - 1));
        chk("in_ready", 32'(o[5]),
            32'((b == n - 1) && (k == p - 1)));
        if (b == n - 1)
          chk("run_par", 32'(o[1]),
              32'(par ^ s));
        cyc();
      end
    end
    bit_tick = 1'b0;
  endtask

  task automatic accept(
    input logic       s,
    input logic [7:0] d
  );
    logic [5:0] o;
    in_data  = d;
    bit_tick = 1'b0;
    if (s) vb = 1'b1;
    else   va = 1'b1;
    #1;
    o = outs(s);
    chk("accept_ready", 32'(o[5]), 32'd1);
    cyc();
    va = 1'b0;
    vb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [5:0] o;
    tbl[0] = '{1'b0, 8'hA5, 1, 1'b0, 1};
    tbl[1] = '{1'b0, 8'h07, 4, 1'b1, 2};
    tbl[2] = '{1'b0, 8'h3C, 2, 1'b0, 3};
    tbl[3] = '{1'b0, 8'h80, 1, 1'b1, 4};
    tbl[4] = '{1'b1, 8'h00, 1, 1'b1, 1};
    tbl[5] = '{1'b1, 8'hFF, 2, 1'b1, 2};
    tbl[6] = '{1'b1, 8'h01, 1, 1'b0, 3};
    tbl[7] = '{1'b1, 8'h0E, 1, 1'b0, 0};

    rst      = 1'b1;
    bit_tick = 1'b0;
    in_data  = 8'h00;
    va       = 1'b0;
    vb       = 1'b0;
    repeat (3) cyc();
    o = outs(1'b0);
    chk("rst_vals", 32'(o), 32'b110000);
    chk("rst_cnt", 32'(fca), 32'd0);
    rst = 1'b0;

    bit_tick = 1'b1;
    repeat (3) cyc();
    chk("idle_tick_busy", 32'(ba), 32'd0);
    chk("idle_tick_ser", 32'(soa), 32'd1);
    bit_tick = 1'b0;

    foreach (tbl[i]) begin
      accept(tbl[i].sel, tbl[i].data);
      frame_body(tbl[i].sel, tbl[i].data,
                 tbl[i].per, tbl[i].par);
      o = outs(tbl[i].sel);
      chk("end_busy", 32'(o[0]), 32'd0);
      chk("frame_cnt", 32'(cnt_of(tbl[i].sel)),
          32'(tbl[i].cnt));
    end

    // abort mid-frame on DATA bit 3
    accept(1'b0, 8'hA5);
    bit_tick = 1'b1;
    repeat (NSTART + 3) cyc();
    #1;
    chk("pre_abort_bit", 32'(soa), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bit_tick = 1'b0;
    o = outs(1'b0);
    chk("abort_vals", 32'(o), 32'b110000);
    chk("abort_cnt", 32'(fca), 32'd0);

    // back-to-back with in_valid held high
    in_data = 8'h01;
    va = 1'b1;
    #1;
    chk("b2b_ready", 32'(ra), 32'd1);
    cyc();
    in_data = 8'h80;
    frame_body(1'b0, 8'h01, 1, 1'b1);
    va = 1'b0;
    frame_body(1'b0, 8'h80, 1, 1'b1);
    chk("b2b_busy", 32'(ba), 32'd0);
    chk("b2b_cnt", 32'(fca), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
